// File: rtl/acslip_sample_adjust_pkg.sv
// Shared types and helpers for the ACSLIP sample-adjust block and the
// ACSLIP debug counters.
package acslip_sample_adjust_pkg;

    typedef enum logic [2:0] {
        ST_PASS = 3'd0,
        ST_DROP = 3'd1,
        ST_DUP  = 3'd2,
        ST_CLR  = 3'd3,
        ST_HOLD = 3'd4
    } adj_state_e;

    localparam int DEF_SLIP_THRESH    = 2;
    localparam int DEF_HOLDOFF_CYCLES = 8;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == '1) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/acslip_sample_adjust_out_reg.sv
// Single-entry output register with valid/ready handshake; remembers the
// last written word so it can be re-emitted as a duplicate.
module acslip_out_reg
    import acslip_sample_adjust_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  load_dup_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  free_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic                  valid_q, valid_d;

    // A load in the same cycle as a drain simply replaces the drained word.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            last_d  = data_i;
            valid_d = 1'b1;
        end else if (load_dup_i) begin
            data_d  = last_q;
            valid_d = 1'b1;
        end else if (m_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
    assign free_o    = ~valid_q | m_ready_i;

endmodule

// File: rtl/acslip_sample_adjust.sv
// Keeps the I2S-derived 16 kHz sample stream locked to the reference clock
// by dropping or duplicating a sample when the ACSLIP slip count drifts.
module acslip_sample_adjust
    import acslip_sample_adjust_pkg::*;
#(
    parameter int ACSLIP_REG_WIDTH = 32,
    parameter int DATA_WIDTH       = 16,
    parameter int SLIP_THRESH      = DEF_SLIP_THRESH,
    parameter int HOLDOFF_CYCLES   = DEF_HOLDOFF_CYCLES
) (
    input  logic                        wbs_clk_i,
    input  logic                        wbs_rst_i,
    input  logic                        enable_i,
    input  logic [ACSLIP_REG_WIDTH-1:0] acslip_cnt_i,
    output logic                        acslip_reg_rst_o,
    input  logic [DATA_WIDTH-1:0]       s_data_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    output logic [DATA_WIDTH-1:0]       m_data_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [15:0]                 drop_cnt_o,
    output logic [15:0]                 dup_cnt_o,
    output logic                        adj_irq_o
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic signed [ACSLIP_REG_WIDTH-1:0] THR_POS = ACSLIP_REG_WIDTH'(SLIP_THRESH);
    localparam logic signed [ACSLIP_REG_WIDTH-1:0] THR_NEG = -THR_POS;

    adj_state_e                   state_q, state_d;
    logic [HOLD_W-1:0]            hold_q, hold_d;
    logic [15:0]                  drop_cnt_q, drop_cnt_d;
    logic [15:0]                  dup_cnt_q, dup_cnt_d;
    logic signed [ACSLIP_REG_WIDTH-1:0] slip_s;
    logic                         slip_pos, slip_neg;
    logic                         out_free, load, load_dup;

    // Signed compare against the threshold; most-negative count cannot overflow.
    assign slip_s   = acslip_cnt_i;
    assign slip_pos = (slip_s >= THR_POS);
    assign slip_neg = (slip_s <= THR_NEG);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        drop_cnt_d = drop_cnt_q;
        dup_cnt_d  = dup_cnt_q;
        s_ready_o  = out_free;
        load       = 1'b0;
        load_dup   = 1'b0;
        if (!enable_i) begin
            state_d = ST_PASS;
            load    = s_valid_i & out_free;
        end else begin
            case (state_q)
                ST_PASS: begin
                    load = s_valid_i & out_free;
                    if (slip_pos) begin
                        state_d = ST_DROP;
                    end else if (slip_neg) begin
                        state_d = ST_DUP;
                    end
                end
                ST_DROP: begin
                    s_ready_o = 1'b1;
                    if (s_valid_i) begin
                        drop_cnt_d = sat_inc16(drop_cnt_q);
                        state_d    = ST_CLR;
                    end
                end
                ST_DUP: begin
                    s_ready_o = 1'b0;
                    if (out_free) begin
                        load_dup  = 1'b1;
                        dup_cnt_d = sat_inc16(dup_cnt_q);
                        state_d   = ST_CLR;
                    end
                end
                ST_CLR: begin
                    load    = s_valid_i & out_free;
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    load = s_valid_i & out_free;
                    if (hold_q == '0) begin
                        state_d = ST_PASS;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: state_d = ST_PASS;
            endcase
        end
    end

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            state_q    <= ST_PASS;
            hold_q     <= '0;
            drop_cnt_q <= '0;
            dup_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            drop_cnt_q <= drop_cnt_d;
            dup_cnt_q  <= dup_cnt_d;
        end
    end

    acslip_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk        (wbs_clk_i),
        .rst        (wbs_rst_i),
        .load_i     (load),
        .load_dup_i (load_dup),
        .data_i     (s_data_i),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .free_o     (out_free)
    );

    // CLR lasts exactly one cycle, so a state decode gives a clean pulse.
    assign acslip_reg_rst_o = (state_q == ST_CLR);
    assign adj_irq_o        = (state_q == ST_CLR);
    assign drop_cnt_o       = drop_cnt_q;
    assign dup_cnt_o        = dup_cnt_q;

endmodule
